// File: rtl/id_load_scoreboard_if.sv
// Decode-stage load-use interlock signals: instruction issue, load writeback,
// flush, and the scoreboard's ready/stall/status outputs.
interface id_load_scoreboard_if #(
  parameter int unsigned AW    = 5,
  parameter int unsigned TOT_W = 3
);
  logic          flush;
  logic          issue_valid;
  logic          issue_is_load;
  logic [AW-1:0] issue_waddr;
  logic          src1_use;
  logic [AW-1:0] src1_addr;
  logic          src2_use;
  logic [AW-1:0] src2_addr;
  logic          wb_valid;
  logic [AW-1:0] wb_waddr;
  logic          issue_ready;
  logic          stall_req;
  logic [TOT_W-1:0] total_out;
  logic          wb_err;
  logic [31:0]   stall_cycles;

  modport master (
    output flush, issue_valid, issue_is_load, issue_waddr,
           src1_use, src1_addr, src2_use, src2_addr, wb_valid, wb_waddr,
    input  issue_ready, stall_req, total_out, wb_err, stall_cycles
  );

  modport slave (
    input  flush, issue_valid, issue_is_load, issue_waddr,
           src1_use, src1_addr, src2_use, src2_addr, wb_valid, wb_waddr,
    output issue_ready, stall_req, total_out, wb_err, stall_cycles
  );
endinterface

// File: rtl/id_load_scoreboard.sv
// Load-use interlock: per-register outstanding-load counters with a global
// in-flight limit, same-cycle writeback bypass, flush and stall statistics.
module id_load_scoreboard #(
  parameter int unsigned NREG    = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned TOT_W   = 3
) (
  input logic clk,
  input logic rst_n,
  id_load_scoreboard_if.slave bus
);
  localparam int unsigned NSLOT = 1 << AW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TOT_W-1:0] TOT_MAX = TOT_W'(MAX_OUT);

  // Sized to the full address space so any address indexes safely; slots at
  // 0 and at NREG and above are never incremented and read as zero.
  logic [CNT_W-1:0] cnt     [NSLOT];
  logic [CNT_W-1:0] cnt_nxt [NSLOT];
  logic [TOT_W-1:0] total, total_nxt;
  logic             wb_err;
  logic [31:0]      stall_cycles;

  logic src1_busy, src2_busy, dest_full, ready, fire, inc, dec, err_set, stall;

  function automatic logic tracked(input logic [AW-1:0] a);
    return (a != '0) && (32'(a) < NREG);
  endfunction

  function automatic logic busy(input logic used, input logic [AW-1:0] a,
                                input logic [CNT_W-1:0] c, input logic wbv,
                                input logic [AW-1:0] wba);
    logic bypass;
    bypass = wbv && (wba == a) && (c == CNT_W'(1));
    return used && tracked(a) && (c != '0) && !bypass;
  endfunction

  always_comb begin
    src1_busy = busy(bus.src1_use, bus.src1_addr, cnt[bus.src1_addr],
                     bus.wb_valid, bus.wb_waddr);
    src2_busy = busy(bus.src2_use, bus.src2_addr, cnt[bus.src2_addr],
                     bus.wb_valid, bus.wb_waddr);
    dest_full = bus.issue_is_load && tracked(bus.issue_waddr) &&
                ((cnt[bus.issue_waddr] == CNT_MAX) || (total == TOT_MAX));
    ready     = !(src1_busy || src2_busy || dest_full);
    fire      = bus.issue_valid && ready;
    inc       = fire && bus.issue_is_load && tracked(bus.issue_waddr);
    dec       = bus.wb_valid && tracked(bus.wb_waddr) && (cnt[bus.wb_waddr] != '0);
    err_set   = bus.wb_valid && !dec;
    stall     = bus.issue_valid && !ready;
  end

  // Sequential +1 then -1 leaves a same-register inc/dec pair unchanged;
  // inc is only possible below CNT_MAX so the intermediate value cannot wrap.
  always_comb begin
    cnt_nxt   = cnt;
    total_nxt = total;
    if (bus.flush) begin
      cnt_nxt   = '{default: '0};
      total_nxt = '0;
    end else begin
      if (inc) cnt_nxt[bus.issue_waddr] = cnt_nxt[bus.issue_waddr] + 1'b1;
      if (dec) cnt_nxt[bus.wb_waddr]    = cnt_nxt[bus.wb_waddr] - 1'b1;
      if (inc && !dec)      total_nxt = total + 1'b1;
      else if (dec && !inc) total_nxt = total - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '{default: '0};
      total        <= '0;
      wb_err       <= 1'b0;
      stall_cycles <= '0;
    end else begin
      cnt   <= cnt_nxt;
      total <= total_nxt;
      if (err_set) wb_err <= 1'b1;
      if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
    end
  end

  assign bus.issue_ready  = ready;
  assign bus.stall_req    = stall;
  assign bus.total_out    = total;
  assign bus.wb_err       = wb_err;
  assign bus.stall_cycles = stall_cycles;
endmodule

// File: doc/id_load_scoreboard.md
# id_load_scoreboard

Parametrised load-use interlock for the decode stage. It tracks outstanding load destinations per architectural register and stalls any instruction whose source register is still waiting on a load. It replaces the fixed forwarding-only hazard handling between ID and the EX/MEM/WB stages. Per-register counters are bounded and there is a global outstanding-load limit. The block also provides a flush, a same-cycle writeback bypass and a saturating stall-cycle performance counter.

## Interface
Parameters:
- NREG, 32: number of architectural registers. Register 0 is never tracked.
- AW, 5: register address width (2^AW >= NREG).
- CNT_W, 2: per-register pending counter width. Per-register maximum is 2^CNT_W-1.
- MAX_OUT, 4: maximum total loads in flight across all registers.
- TOT_W, 3: width of the total counter. Must satisfy MAX_OUT < 2^TOT_W.

Ports (reset is asynchronous and active-low; clock and reset ports are named as in the codebase):
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- flush, in, 1: drop all outstanding loads.
- issue_valid, in, 1: ID holds an instruction wishing to issue.
- issue_is_load, in, 1: the instruction is a load with a register destination.
- issue_waddr, in, AW: load destination register.
- src1_use, in, 1: source 1 is read by the instruction.
- src1_addr, in, AW: source 1 register address.
- src2_use, in, 1: source 2 is read by the instruction.
- src2_addr, in, AW: source 2 register address.
- wb_valid, in, 1: a load result is written to the regfile this cycle.
- wb_waddr, in, AW: register written by that load.
- issue_ready, out, 1: the instruction may issue this cycle.
- stall_req, out, 1: stall request to the stall controller (= issue_valid & ~issue_ready).
- total_out, out, TOT_W: number of loads currently in flight.
- wb_err, out, 1: sticky flag set by a load writeback to a register with count 0.
- stall_cycles, out, 32: saturating count of cycles with stall_req high.

## Operation
- State:
  - cnt[r], CNT_W bits, for r = 1..NREG-1.
  - total, TOT_W bits.
  - wb_err.
  - stall_cycles.
- A source is busy when its use bit is 1, its address is non-zero, and its cnt > 0.
- Same-cycle bypass: a source is not busy if wb_valid & wb_waddr == src_addr & cnt == 1.
- Destination is full when issue_is_load & issue_waddr != 0 & (cnt[issue_waddr] == 2^CNT_W-1 | total == MAX_OUT).
  - A same-cycle writeback does not relieve the full condition; this is conservative.
- issue_ready = ~(src1 busy | src2 busy | dest full). It is combinational from the current state and the current inputs.
- fire = issue_valid & issue_ready.
- inc = fire & issue_is_load & issue_waddr != 0. Increments cnt[issue_waddr] and total.
- dec = wb_valid & wb_waddr != 0 & cnt[wb_waddr] > 0. Decrements cnt[wb_waddr] and total.
- inc and dec on the same register in the same cycle: cnt is unchanged and total is unchanged.
- inc and dec on different registers: each cnt updates independently and total is unchanged.
- wb_valid to a register with cnt == 0, or to register 0: no counter change, and wb_err is set.
  - wb_err stays set until reset.
  - Writes to register 0 are ignored without setting wb_err only if wb_waddr == 0 and ~wb_valid.
- flush (highest priority): the next state is all cnt = 0 and total = 0, regardless of inc/dec.
  - issue_ready in the flush cycle still follows the pre-flush state.
- stall_cycles increments each cycle stall_req = 1 and holds at 32'hFFFF_FFFF.
- No arithmetic wraps: cnt and total are guarded by the full and dec conditions above.

## Timing
- Reset (rst_n low, asynchronous):
  - all cnt = 0, total_out = 0, wb_err = 0, stall_cycles = 0.
  - issue_ready = 1 whenever no source is busy (always true immediately after reset).
- Reset asserted mid-operation discards all pending state on the spot. No writeback after reset release is expected; any that arrives sets wb_err.
- Load issued in cycle T: the dependent source is busy from T+1.
- Matching writeback in cycle W: the dependent instruction issues in W itself (bypass) when cnt was 1.
- issue_ready has zero latency: it is combinational. All counters update on the rising clk edge.
- total_out and wb_err are registered outputs.

## Test plan
- Reset, then issue a load to r5 and, next cycle, an add reading r5 -> stall_req = 1 and total_out = 1. Assert wb_valid with r5 -> add issues in the same cycle, total_out = 0 next cycle, stall_cycles = 1 or more as stalled.
- Issue 4 loads to r1, r2, r3, r4 (MAX_OUT = 4), then a load to r6 -> r6 load stalled with total_out = 4. Write back r1 -> r6 load issues the next cycle.
- Issue 3 loads to r7 (CNT_W = 2) followed by a 4th load to r7 -> 4th stalled. A reader of r7 is not bypassed until cnt == 1.
- Same-cycle load issue to r9 and writeback of r9 with cnt[r9] = 1 -> cnt[r9] stays 1 and total_out is unchanged.
- Load to r0 with a reader of r0 -> no count, never stalls. Writeback to r12 with cnt = 0 -> wb_err = 1 and sticky.
- Two loads pending, assert flush -> next cycle total_out = 0 and the reader issues. Drop rst_n mid-stall -> all outputs return to reset values immediately.
